// File: rtl/dsp_mac_pipe_if.sv
// Sample/result bundle for dsp_mac_pipe: input sample handshake plus result handshake.
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready carry the stall in both directions.
interface dsp_mac_pipe_if #(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int PW = 48
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
    logic signed [BW-1:0] d;
    logic signed [PW-1:0] c;
    logic                 pre_en;
    logic                 pre_sub;
    logic                 post_sub;
    logic                 first;
    logic                 last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] p;
    logic                 ovf;

    modport master (
        output in_valid, a, b, d, c, pre_en, pre_sub, post_sub, first, last, out_ready,
        input  in_ready, out_valid, p, ovf
    );

    modport slave (
        input  in_valid, a, b, d, c, pre_en, pre_sub, post_sub, first, last, out_ready,
        output in_ready, out_valid, p, ovf
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Signed pre-add / multiply / packet accumulate with saturation, round-half-up and shift.
// Latency: result registers 3 edges after the accepting edge (2 when MREG = 0).
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module dsp_mac_pipe #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter int MREG   = 1,
    parameter int SAT_EN = 1,
    parameter int SHIFT  = 0
) (
    input  logic          CLK,
    input  logic          RSTA,
    dsp_mac_pipe_if.slave bus
);
    localparam int MW = AW + BW + 1;
    localparam logic signed [PW-1:0] MAXV = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {1'b1, {(PW-1){1'b0}}};
    localparam logic [PW:0] RND = (SHIFT > 0) ? ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic adv;
    logic out_vld;
    logic signed [PW-1:0] p_q;
    logic ovf_q;

    assign adv           = !(out_vld && !bus.out_ready);
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_vld;
    assign bus.p         = p_q;
    assign bus.ovf       = ovf_q;

    // S1 stage registers
    logic                 s1_vld, s1_pre_en, s1_pre_sub, s1_post_sub, s1_first, s1_last;
    logic signed [AW-1:0] s1_a;
    logic signed [BW-1:0] s1_b, s1_d;
    logic signed [PW-1:0] s1_c;

    // S1: capture the accepted sample; a bubble is captured as an invalid stage
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            s1_vld <= 1'b0; s1_pre_en <= 1'b0; s1_pre_sub <= 1'b0; s1_post_sub <= 1'b0;
            s1_first <= 1'b0; s1_last <= 1'b0;
            s1_a <= '0; s1_b <= '0; s1_d <= '0; s1_c <= '0;
        end else if (adv) begin
            s1_vld <= bus.in_valid; s1_pre_en <= bus.pre_en; s1_pre_sub <= bus.pre_sub;
            s1_post_sub <= bus.post_sub; s1_first <= bus.first; s1_last <= bus.last;
            s1_a <= bus.a; s1_b <= bus.b; s1_d <= bus.d; s1_c <= bus.c;
        end
    end

    // Pre-adder is one bit wider than its operands so it can never overflow
    logic signed [BW:0] pre_w;

    // Pre-adder select: d+b, d-b or b passed straight through
    always_comb begin
        pre_w = {s1_b[BW-1], s1_b};
        if (s1_pre_en) begin
            if (s1_pre_sub) pre_w = {s1_d[BW-1], s1_d} - {s1_b[BW-1], s1_b};
            else            pre_w = {s1_d[BW-1], s1_d} + {s1_b[BW-1], s1_b};
        end
    end

    logic                 s2_vld, s2_post_sub, s2_first, s2_last;
    logic signed [BW:0]   s2_pre;
    logic signed [AW-1:0] s2_a;
    logic signed [PW-1:0] s2_c;

    // S2: register pre-adder result and carry the rest of the sample along
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            s2_vld <= 1'b0; s2_post_sub <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
            s2_pre <= '0; s2_a <= '0; s2_c <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld; s2_post_sub <= s1_post_sub; s2_first <= s1_first;
            s2_last <= s1_last; s2_pre <= pre_w; s2_a <= s1_a; s2_c <= s1_c;
        end
    end

    logic signed [MW-1:0] prod_w;
    logic signed [PW-1:0] prod_ext;
    assign prod_w   = s2_pre * s2_a;
    assign prod_ext = {{(PW-MW){prod_w[MW-1]}}, prod_w};

    logic                 m_vld, m_post_sub, m_first, m_last;
    logic signed [PW-1:0] m_prod, m_c;

    generate
        if (MREG != 0) begin : g_mreg
            // S3: registered multiplier output
            always_ff @(posedge CLK or posedge RSTA) begin
                if (RSTA) begin
                    m_vld <= 1'b0; m_post_sub <= 1'b0; m_first <= 1'b0; m_last <= 1'b0;
                    m_prod <= '0; m_c <= '0;
                end else if (adv) begin
                    m_vld <= s2_vld; m_post_sub <= s2_post_sub; m_first <= s2_first;
                    m_last <= s2_last; m_prod <= prod_ext; m_c <= s2_c;
                end
            end
        end else begin : g_nomreg
            assign m_vld      = s2_vld;
            assign m_post_sub = s2_post_sub;
            assign m_first    = s2_first;
            assign m_last     = s2_last;
            assign m_prod     = prod_ext;
            assign m_c        = s2_c;
        end
    endgenerate

    logic signed [PW-1:0] base, acc, acc_new, rnd_sat, r;
    logic [PW:0]          sum, rnd;
    logic                 sum_ovf, pkt_ovf, pkt_ovf_new;

    // Accumulate in PW+1 bits, clamp or wrap, then round-half-up and shift the result
    always_comb begin
        base    = m_first ? m_c : acc;
        sum     = m_post_sub ? ({base[PW-1], base} - {m_prod[PW-1], m_prod})
                             : ({base[PW-1], base} + {m_prod[PW-1], m_prod});
        sum_ovf = sum[PW] ^ sum[PW-1];
        acc_new = sum[PW-1:0];
        if (sum_ovf && (SAT_EN != 0)) acc_new = sum[PW] ? MINV : MAXV;
        pkt_ovf_new = (m_first ? 1'b0 : pkt_ovf) | sum_ovf;
        // Rounding constant is non-negative, so only the positive rail can be crossed
        rnd     = {acc_new[PW-1], acc_new} + RND;
        rnd_sat = rnd[PW-1:0];
        if ((SAT_EN != 0) && (rnd[PW] ^ rnd[PW-1])) rnd_sat = MAXV;
        r = rnd_sat >>> SHIFT;
    end

    // S4: accumulator and sticky packet overflow; bubbles leave them untouched
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            acc     <= '0;
            pkt_ovf <= 1'b0;
        end else if (adv && m_vld) begin
            acc     <= acc_new;
            pkt_ovf <= pkt_ovf_new;
        end
    end

    // Result register: load on last, otherwise drop valid once the consumer takes it
    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            out_vld <= 1'b0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            if (m_vld && m_last) begin
                out_vld <= 1'b1;
                p_q     <= r;
                ovf_q   <= pkt_ovf_new;
            end else if (bus.out_ready) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule
